// File: rtl/r200_memarb.sv
// r200_memarb: arbitrates the r200 fetch stage and the MEM-stage load/store
// path onto one single-port synchronous memory. Grants are combinational and
// in-flight reads are tracked by a MEM_LAT-deep tag pipeline that routes read
// data back to the owner and squashes fetch responses killed by a redirect.
// Optional feature: define R200_MEMARB_STARVE_EN to enable the fetch
// anti-starvation counter and STARVED state; otherwise data has strict priority.
module r200_memarb #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
        $error("r200_memarb: MEM_LAT must be 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("r200_memarb: STARVE_MAX must be 1..15");
    end

    localparam int unsigned Tail = MEM_LAT - 1;

    logic fetch_win;

`ifdef R200_MEMARB_STARVE_EN
    typedef enum logic {StRun, StStarved} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e     state_q;
    logic [3:0] starve_q;

    // StStarved is held exactly while the counter sits at its saturation value
    assign fetch_win = ~d_req | (state_q == StStarved);

    // Count consecutive denied fetch cycles; force fetch once saturated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            state_q  <= StRun;
        end else if (flush || !if_req || if_gnt) begin
            starve_q <= '0;
            state_q  <= StRun;
        end else if (starve_q != StarveMax) begin
            starve_q <= starve_q + 4'd1;
            if (starve_q + 4'd1 == StarveMax) begin
                state_q <= StStarved;
            end
        end
    end
`else
    assign fetch_win = ~d_req;
`endif

    // Grants are gated by reset so all outputs drop the moment reset asserts
    assign if_gnt = rst & if_req & ~flush & fetch_win;
    assign d_gnt  = rst & d_req & ~if_gnt;

    // Drive the memory port from whichever requester won this cycle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Tag pipeline: valid / owner (1 = data) / kill per in-flight read
    logic [MEM_LAT-1:0] vld_q, vld_d;
    logic [MEM_LAT-1:0] own_q, own_d;
    logic [MEM_LAT-1:0] kill_q, kill_d;

    // Shift tags toward the tail; a redirect kills every fetch entry in flight
    always_comb begin
        vld_d     = '0;
        own_d     = '0;
        kill_d    = '0;
        vld_d[0]  = mem_en & ~mem_we;
        own_d[0]  = d_gnt;
        kill_d[0] = 1'b0;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            own_d[i]  = own_q[i-1];
            kill_d[i] = kill_q[i-1] | (flush & vld_q[i-1] & ~own_q[i-1]);
        end
    end

    // Register the tag pipeline; reset drops every outstanding read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            own_q  <= '0;
            kill_q <= '0;
        end else begin
            vld_q  <= vld_d;
            own_q  <= own_d;
            kill_q <= kill_d;
        end
    end

    // A flush coinciding with a fetch response at the tail also squashes it
    assign if_rvalid = vld_q[Tail] & ~own_q[Tail] & ~kill_q[Tail] & ~flush;
    assign d_rvalid  = vld_q[Tail] & own_q[Tail];
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_r200_memarb.sv
// tb_r200_memarb: scoreboard bench for r200_memarb. A reference model predicts
// grants and read responses from the arbitration rules; a separate monitor
// pops expected responses and compares whenever the DUT presents them.
module tb_r200_memarb;

    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        flush = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'hF;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    r200_memarb #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .flush     (flush),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Memory macro model driven by the DUT's mem_* port
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_pipe [MEM_LAT];
    initial for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        logic [31:0] w;
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        w = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
        if (mem_en && !mem_we) begin
            rd_pipe[0] <= w;
        end else begin
            rd_pipe[0] <= $urandom;
        end
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = w;
        end
    end

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    int          denied = 0;
    logic        hs_if = 1'b0;
    logic        hs_d = 1'b0;

    // Predict this cycle's grants and bus, and queue the responses they imply
    always @(negedge clk) begin
        logic        e_if, e_d, force_f;
        logic [37:0] e_ctl;
        logic [31:0] w;
        exp_t        e;
        e_if = 1'b0;
        e_d  = 1'b0;
        if (!rst) begin
            if_q.delete();
            d_q.delete();
            denied = 0;
        end else begin
            if (flush) if_q.delete();
`ifdef R200_MEMARB_STARVE_EN
            force_f = (denied >= STARVE_MAX);
`else
            force_f = 1'b0;
`endif
            e_if = if_req && !flush && (!d_req || force_f);
            e_d  = d_req && !e_if;
            if (if_req && !e_if && !flush) denied = (denied < STARVE_MAX) ? denied + 1 : denied;
            else denied = 0;
            if (e_if) begin
                e.due  = cyc + MEM_LAT;
                e.data = ref_mem.exists(if_addr) ? ref_mem[if_addr] : init_word(if_addr);
                if_q.push_back(e);
            end
            if (e_d) begin
                w = ref_mem.exists(d_addr) ? ref_mem[d_addr] : init_word(d_addr);
                if (d_we) begin
                    for (int b = 0; b < 4; b++) if (d_be[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                    ref_mem[d_addr] = w;
                end else begin
                    e.due  = cyc + MEM_LAT;
                    e.data = w;
                    d_q.push_back(e);
                end
            end
        end
        check("if_gnt", 128'(if_gnt), 128'(e_if));
        check("d_gnt", 128'(d_gnt), 128'(e_d));
        if (e_if) e_ctl = {1'b1, 1'b0, 4'hF, if_addr};
        else if (e_d) e_ctl = {1'b1, d_we, d_be, d_addr};
        else e_ctl = '0;
        check("mem_ctl", 128'({mem_en, mem_we, mem_be, mem_addr}), 128'(e_ctl));
        if (!e_if) check("mem_wdata", 128'(mem_wdata), 128'(e_d ? d_wdata : 32'h0));
        hs_if = if_gnt;
        hs_d  = d_gnt;
    end

    // Monitor: compare responses against the scoreboard queues
    always begin
        logic ev;
        exp_t e;
        @(negedge clk);
        #1;
        ev = (if_q.size() != 0) && (if_q[0].due == cyc);
        check("if_rvalid", 128'(if_rvalid), 128'(ev));
        if (ev) begin
            e = if_q.pop_front();
            check("if_rdata", 128'(if_rdata), 128'(e.data));
        end else begin
            check("if_rdata_idle", 128'(if_rdata), 128'h0);
        end
        ev = (d_q.size() != 0) && (d_q[0].due == cyc);
        check("d_rvalid", 128'(d_rvalid), 128'(ev));
        if (ev) begin
            e = d_q.pop_front();
            check("d_rdata", 128'(d_rdata), 128'(e.data));
        end else begin
            check("d_rdata_idle", 128'(d_rdata), 128'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int   first;
    int   k;
    logic dre, gi, gd;

    initial begin
        mem[32'h100]     = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single fetch read
        if_req = 1'b1;
        if_addr = 32'h100;
        tick();
        if_req = 1'b0;
        repeat (4) tick();

        // Fetch/data conflict: data first, fetch the cycle after d_req drops
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        d_req = 1'b0;
        tick();
        if_req = 1'b0;
        repeat (4) tick();

        // Data held for 10 cycles against a waiting fetch
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
        first = -1; dre = 1'b0; k = 0;
        for (int i = 0; i < 10; i++) begin
            d_addr = 32'h400 + 32'(4 * k);
            #1;
            gi = if_gnt;
            gd = d_gnt;
            if (gi && first < 0) first = i;
            if (first >= 0 && i == first + 1) dre = gd;
            @(posedge clk);
            #1;
            if (gi) if_addr = if_addr + 32'd4;
            if (gd) k++;
        end
        d_req = 1'b0;
        if_req = 1'b0;
`ifdef R200_MEMARB_STARVE_EN
        check("starve_first_fetch", 128'(first), 128'(4));
        check("starve_data_regrant", 128'(dre), 128'(1'b1));
`else
        check("strict_priority", 128'(first), 128'(-1));
`endif
        repeat (4) tick();

        // Fetch at cycle 0, redirect at cycle 1 kills it and blocks the next
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        if_addr = 32'h504; flush = 1'b1;
        tick();
        flush = 1'b0; if_req = 1'b0;
        repeat (4) tick();

        // Partial store, then read it back
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h600; d_wdata = 32'h1234ABCD;
        tick();
        d_we = 1'b0; d_be = 4'hF;
        tick();
        d_req = 1'b0;
        repeat (4) tick();

        // Reset one cycle after a read grant
        if_req = 1'b1; if_addr = 32'h700;
        tick();
        rst = 1'b0;
        d_req = 1'b1; d_addr = 32'h704;
        #1;
        check("rst_outputs", 128'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be,
                                  mem_addr, mem_wdata}), 128'h0);
        check("rst_rdata", 128'({if_rdata, d_rdata}), 128'h0);
        tick();
        tick();
        if_req = 1'b0; d_req = 1'b0;
        rst = 1'b1;
        repeat (5) tick();

        // Randomized traffic with redirects and occasional reset
        for (int n = 0; n < 3000; n++) begin
            if (!if_req || hs_if) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (!d_req || hs_d) begin
                d_req   = ($urandom_range(0, 9) < 7);
                d_we    = $urandom_range(0, 2) == 0;
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = 32'($urandom_range(0, 63)) << 2;
                d_wdata = $urandom;
            end
            flush = ($urandom_range(0, 19) == 0);
            if (n % 700 == 350) rst = 1'b0;
            else rst = 1'b1;
            tick();
        end
        if_req = 1'b0; d_req = 1'b0; flush = 1'b0; rst = 1'b1;
        repeat (MEM_LAT + 4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
